// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Frame: SYNC, LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Parses a framed byte stream into little-endian words and writes them
// to the instruction memory, holding the CPU in reset until a good load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [7:0] SYNC_BYTE = loader_pkg::SYNC_BYTE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            imem_we,
  output logic [31:0]     imem_waddr,
  output logic [31:0]     imem_wdata,
  output logic            cpu_rst_n,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] words_written
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WORD_ONE = 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] word_q, word_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     buf_q, buf_d;
  logic [7:0]      xor_q, xor_d;
  logic            we_q, we_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     len_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      buf_q   <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;
    len_n   = {rx_data, len_q[7:0]};

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN0;
            word_d  = '0;
            bcnt_d  = '0;
            xor_d   = '0;
            run_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_LEN0: begin
          len_d   = {len_q[15:8], rx_data};
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d = len_n;
          if ({16'd0, len_n} > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (len_n == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          buf_d  = {rx_data, buf_q[23:8]};
          xor_d  = xor_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == LAST_BYTE) begin
            we_d    = 1'b1;
            waddr_d = 32'(word_q) << 2;
            wdata_d = {rx_data, buf_q};
            word_d  = word_q + WORD_ONE;
            bcnt_d  = '0;
            // the length check in LEN1 keeps word_q from wrapping
            if (32'(word_q) + 32'd1 == 32'(len_q))
              state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data == xor_q) begin
            done_d  = 1'b1;
            run_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_we       = we_q;
  assign imem_waddr    = waddr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_rst_n     = run_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_written = word_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-level model pushes
// expected writes into a scoreboard popped by a write monitor.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            imem_we;
  logic [31:0]     imem_waddr;
  logic [31:0]     imem_wdata;
  logic            cpu_rst_n;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] words_written;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .load_done(load_done),
    .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int n_vec = 0;
  int n_bad = 0;
  wr_t sb[$];
  logic [7:0] frm[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      if (sb.size() == 0) begin
        chk("spurious_we", imem_waddr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("waddr", imem_waddr, e.a);
        chk("wdata", imem_wdata, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends frm[from..to-1]; models the expected writes of that span.
  task automatic send_frame(input int gap, input int from, input int to);
    int n;
    logic [31:0] w;
    n = int'({frm[2], frm[1]});
    w = '0;
    for (int i = 0; i < frm.size() && i < to; i++) begin
      if (i >= 3 && n <= 256 && i < 3 + 4 * n) begin
        w = {frm[i], w[31:8]};
        if ((i - 3) % 4 == 3 && i >= from)
          sb.push_back('{a: 32'((i - 3) / 4 * 4), d: w});
      end
      if (i >= from) send_byte(frm[i], gap);
    end
  endtask

  task automatic mk_normal();
    frm = {8'hA5, 8'h03, 8'h00,
           8'h93, 8'h00, 8'ha0, 8'h00,
           8'h13, 8'h01, 8'h40, 8'h01,
           8'hb3, 8'h81, 8'h20, 8'h00,
           8'h72};
  endtask

  task automatic mk_rand(input int n);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    frm = {8'hA5, 8'(n), 8'(n >> 8)};
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      x = x ^ b;
    end
    frm.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", imem_waddr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_ww", 32'(words_written), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // normal load, gaps between bytes
    mk_normal();
    send_frame(2, 0, 1000);
    chk("n_done", 32'(load_done), 32'd1);
    chk("n_cpu", 32'(cpu_rst_n), 32'd1);
    chk("n_err", 32'(load_err), 32'd0);
    chk("n_ww", 32'(words_written), 32'd3);
    idle(3);
    chk("n_sb", 32'(sb.size()), 32'd0);

    // bad checksum; sync drops the CPU reset immediately
    mk_normal();
    frm[15] = 8'h73;
    send_frame(1, 0, 1);
    chk("b_sync_cpu", 32'(cpu_rst_n), 32'd0);
    chk("b_sync_done", 32'(load_done), 32'd0);
    send_frame(1, 1, 1000);
    chk("b_err", 32'(load_err), 32'd1);
    chk("b_done", 32'(load_done), 32'd0);
    chk("b_cpu", 32'(cpu_rst_n), 32'd0);
    chk("b_ww", 32'(words_written), 32'd3);
    idle(3);
    chk("b_sb", 32'(sb.size()), 32'd0);

    // empty image
    frm = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1, 0, 1000);
    chk("e_done", 32'(load_done), 32'd1);
    chk("e_err", 32'(load_err), 32'd0);
    chk("e_ww", 32'(words_written), 32'd0);

    // oversize image: error right after LEN_HI
    frm = {8'hA5, 8'h01, 8'h01};
    send_frame(0, 0, 1000);
    chk("o_err", 32'(load_err), 32'd1);
    chk("o_done", 32'(load_done), 32'd0);
    chk("o_cpu", 32'(cpu_rst_n), 32'd0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 1);
    chk("o_ww", 32'(words_written), 32'd0);

    // noise in the waiting state, then a back-to-back frame
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    chk("g_err", 32'(load_err), 32'd1);
    chk("g_ww", 32'(words_written), 32'd0);
    mk_normal();
    send_frame(0, 0, 1000);
    chk("g_done", 32'(load_done), 32'd1);
    chk("g_cpu", 32'(cpu_rst_n), 32'd1);
    chk("g_ww", 32'(words_written), 32'd3);
    idle(3);
    chk("g_sb", 32'(sb.size()), 32'd0);

    // largest legal image, back to back
    mk_rand(256);
    send_frame(0, 0, 2000);
    chk("m_done", 32'(load_done), 32'd1);
    chk("m_err", 32'(load_err), 32'd0);
    chk("m_ww", 32'(words_written), 32'd256);
    idle(3);
    chk("m_sb", 32'(sb.size()), 32'd0);

    // reset after 6 payload bytes, then reload
    mk_normal();
    send_frame(1, 0, 9);
    chk("r_ww_pre", 32'(words_written), 32'd1);
    chk("r_cpu_pre", 32'(cpu_rst_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("r_cpu", 32'(cpu_rst_n), 32'd0);
    chk("r_done", 32'(load_done), 32'd0);
    chk("r_err", 32'(load_err), 32'd0);
    chk("r_ww", 32'(words_written), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    mk_normal();
    send_frame(1, 0, 1000);
    chk("r2_done", 32'(load_done), 32'd1);
    chk("r2_cpu", 32'(cpu_rst_n), 32'd1);
    chk("r2_ww", 32'(words_written), 32'd3);
    idle(4);
    chk("r2_sb", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
